// File: rtl/prime_pkg.sv
// Shared types and constants for the trial-division primality tester.
// Optional feature macro used by prime_check: PRIME_CHECK_ODD_SKIP_EN.
package prime_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int D_START   = 2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/prime_check_if.sv
// Request/result bundle between the prime generator loop (master) and prime_check (slave).
interface prime_check_if #(parameter int WIDTH = prime_pkg::WIDTH_DEF);

  logic             go;
  logic [WIDTH-1:0] n;
  logic             ready;
  logic             is_prime;
  logic [WIDTH-1:0] factor;
  logic [WIDTH-1:0] ndiv;
  logic             error;

  modport master (
    output go, n,
    input  ready, is_prime, factor, ndiv, error
  );

  modport slave (
    input  go, n,
    output ready, is_prime, factor, ndiv, error
  );

endinterface

// File: rtl/prime_check_divmod.sv
// Unsigned restoring divider, one quotient bit per cycle, go/ready handshake.
// Divide by zero still completes, with error raised.
module divmod #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              ready,
  output logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] r,
  output logic              error
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] dvs;
  logic [CNT_W-1:0]  cnt;
  logic              ready_q;
  logic              err_q;
  logic [DATA_W:0]   trial;
  logic              take;
  logic              accept;

  assign accept = ready_q && go;
  assign trial  = {rem, quo[DATA_W-1]};
  assign take   = (trial >= {1'b0, dvs});

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b1;
      cnt     <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      ready_q <= 1'b0;
      cnt     <= CNT_W'(DATA_W);
      err_q   <= (b == '0);
    end else if (!ready_q) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) ready_q <= 1'b1;
    end
  end

  // Operands and partial results carry no reset; they are only read once ready returns.
  always_ff @(posedge clk) begin
    if (accept) begin
      quo <= a;
      rem <= '0;
      dvs <= b;
    end else if (!ready_q) begin
      rem <= DATA_W'(take ? (trial - {1'b0, dvs}) : trial);
      quo <= {quo[DATA_W-2:0], take};
    end
  end

  assign ready = ready_q;
  assign q     = quo;
  assign r     = rem;
  assign error = err_q;

endmodule

// File: rtl/prime_check.sv
// Sequential trial-division primality tester driving one divmod instance.
// Build macro PRIME_CHECK_ODD_SKIP_EN: divisors 2,3,5,7,... instead of 2,3,4,5,...
module prime_check
  import prime_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic           clk,
  input  logic           rst,
  prime_check_if.slave   bus
);

  localparam logic [WIDTH-1:0] D_INIT = WIDTH'(D_START);

  state_t           state;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] ndiv_q;
  logic [WIDTH-1:0] factor_q;
  logic [WIDTH-1:0] res_factor;
  logic             ready_q;
  logic             is_prime_q;
  logic             error_q;
  logic             res_prime;
  logic             dm_go;
  logic             wait_first;

  logic             dm_rst;
  logic             dm_ready;
  logic             dm_error;
  logic [WIDTH-1:0] dm_q;
  logic [WIDTH-1:0] dm_r;

  logic             accept;
  logic             eval;
  logic             advance;

  function automatic logic [WIDTH-1:0] next_div(input logic [WIDTH-1:0] d);
`ifdef PRIME_CHECK_ODD_SKIP_EN
    return (d == D_INIT) ? d + WIDTH'(1) : d + WIDTH'(2);
`else
    return d + WIDTH'(1);
`endif
  endfunction

  assign dm_rst  = ~rst;
  assign accept  = (state == IDLE) && bus.go;
  // The first WAIT cycle still sees the divider's ready from before it took the pulse.
  assign eval    = (state == WAIT) && !wait_first && dm_ready;
  assign advance = eval && !dm_error && !(dm_q < d_q) && (dm_r != '0);

  divmod #(.DATA_W(WIDTH)) u_divmod (
    .clk   (clk),
    .rst   (dm_rst),
    .go    (dm_go),
    .a     (n_q),
    .b     (d_q),
    .ready (dm_ready),
    .q     (dm_q),
    .r     (dm_r),
    .error (dm_error)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ready_q    <= 1'b1;
      is_prime_q <= 1'b0;
      factor_q   <= '0;
      ndiv_q     <= '0;
      error_q    <= 1'b0;
      res_prime  <= 1'b0;
      res_factor <= '0;
      dm_go      <= 1'b0;
      wait_first <= 1'b0;
    end else begin
      dm_go <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.go) begin
            ready_q    <= 1'b0;
            ndiv_q     <= '0;
            error_q    <= 1'b0;
            res_prime  <= 1'b0;
            res_factor <= '0;
            state      <= (bus.n < D_INIT) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          dm_go      <= 1'b1;
          ndiv_q     <= ndiv_q + WIDTH'(1);
          wait_first <= 1'b1;
          state      <= WAIT;
        end
        WAIT: begin
          wait_first <= 1'b0;
          if (eval) begin
            if (dm_error) begin
              error_q <= 1'b1;
              state   <= DONE;
            end else if (dm_q < d_q) begin
              res_prime <= 1'b1;
              state     <= DONE;
            end else if (dm_r == '0) begin
              res_factor <= d_q;
              state      <= DONE;
            end else begin
              state <= ISSUE;
            end
          end
        end
        DONE: begin
          ready_q    <= 1'b1;
          is_prime_q <= res_prime;
          factor_q   <= res_factor;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Candidate and divisor are datapath registers, loaded only under FSM control.
  always_ff @(posedge clk) begin
    if (accept) begin
      n_q <= bus.n;
      d_q <= D_INIT;
    end else if (advance) begin
      d_q <= next_div(d_q);
    end
  end

  assign bus.ready    = ready_q;
  assign bus.is_prime = is_prime_q;
  assign bus.factor   = factor_q;
  assign bus.ndiv     = ndiv_q;
  assign bus.error    = error_q;

endmodule
